// File: rtl/lift_sched.sv
// SCAN lift scheduler: latches floor calls, sweeps one direction while requests remain ahead,
// times floor-to-floor travel and door dwell on the slowref tick.
module lift_sched #(
    parameter int unsigned NFLOOR = 8,
    parameter int unsigned FW     = 3,
    parameter int unsigned TRAVEL = 4,
    parameter int unsigned DWELL  = 6
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              slowref,
    input  logic [NFLOOR-1:0] call,
    output logic              upsig,
    output logic              dnsig,
    output logic              moving,
    output logic              door_open,
    output logic [FW-1:0]     floor,
    output logic [NFLOOR-1:0] pend
);

    localparam int unsigned TMAX = (TRAVEL > DWELL) ? TRAVEL : DWELL;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] TravelLoad = TW'(TRAVEL - 1);
    localparam logic [TW-1:0] DwellLoad  = TW'(DWELL - 1);

    typedef enum logic [1:0] {
        StIdle,
        StMove,
        StDoor
    } state_e;

    state_e            state_q, state_d;
    logic [FW-1:0]     floor_q, floor_d;
    logic [NFLOOR-1:0] pend_q, pend_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              dir_q, dir_d;
    logic              up_q, up_d;
    logic              dn_q, dn_d;
    logic              moving_q, moving_d;
    logic              door_q, door_d;

    logic [FW-1:0] new_floor;
    logic          tick_done;
    logic          ahead_cur, behind_cur;
    logic          ahead_new, behind_new;

    // Any latched request strictly above (up=1) or strictly below (up=0) floor f.
    function automatic logic calls_ahead(input logic [NFLOOR-1:0] req,
                                         input logic [FW-1:0]     f,
                                         input logic              up);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NFLOOR; i++) begin
            if (up ? (i > 32'(f)) : (i < 32'(f))) begin
                hit = hit | req[i];
            end
        end
        return hit;
    endfunction

    assign new_floor  = dir_q ? (floor_q + FW'(1)) : (floor_q - FW'(1));
    assign tick_done  = slowref && (timer_q == '0);
    assign ahead_cur  = calls_ahead(pend_q, floor_q, dir_q);
    assign behind_cur = calls_ahead(pend_q, floor_q, !dir_q);
    assign ahead_new  = calls_ahead(pend_q, new_floor, dir_q);
    assign behind_new = calls_ahead(pend_q, new_floor, !dir_q);

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_d    = dir_q;
        up_d     = up_q;
        dn_d     = dn_q;
        moving_d = moving_q;
        door_d   = door_q;
        timer_d  = timer_q;
        pend_d   = pend_q | call;

        if (slowref && (timer_q != '0)) begin
            timer_d = timer_q - TW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (pend_q[floor_q]) begin
                    state_d         = StDoor;
                    door_d          = 1'b1;
                    timer_d         = DwellLoad;
                    pend_d[floor_q] = 1'b0;
                end else if (ahead_cur || behind_cur) begin
                    state_d  = StMove;
                    dir_d    = ahead_cur ? dir_q : !dir_q;
                    up_d     = dir_d;
                    dn_d     = !dir_d;
                    moving_d = 1'b1;
                    timer_d  = TravelLoad;
                end
            end

            StMove: begin
                if (tick_done) begin
                    floor_d = new_floor;
                    if (pend_q[new_floor]) begin
                        // A call at the arrival floor on this cycle is served too.
                        state_d           = StDoor;
                        moving_d          = 1'b0;
                        door_d            = 1'b1;
                        timer_d           = DwellLoad;
                        pend_d[new_floor] = 1'b0;
                    end else if (ahead_new) begin
                        timer_d = TravelLoad;
                    end else if (behind_new) begin
                        dir_d   = !dir_q;
                        up_d    = dir_d;
                        dn_d    = !dir_d;
                        timer_d = TravelLoad;
                    end else begin
                        state_d  = StIdle;
                        moving_d = 1'b0;
                        up_d     = 1'b0;
                        dn_d     = 1'b0;
                    end
                end
            end

            StDoor: begin
                pend_d[floor_q] = 1'b0;
                if (call[floor_q]) begin
                    // Absorbed call: restart the full dwell, taking priority over closing.
                    timer_d = DwellLoad;
                end else if (tick_done) begin
                    door_d = 1'b0;
                    if (ahead_cur || behind_cur) begin
                        state_d  = StMove;
                        dir_d    = ahead_cur ? dir_q : !dir_q;
                        up_d     = dir_d;
                        dn_d     = !dir_d;
                        moving_d = 1'b1;
                        timer_d  = TravelLoad;
                    end else begin
                        state_d = StIdle;
                        up_d    = 1'b0;
                        dn_d    = 1'b0;
                    end
                end
            end

            default: begin
                state_d  = StIdle;
                moving_d = 1'b0;
                door_d   = 1'b0;
                up_d     = 1'b0;
                dn_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q  <= StIdle;
            floor_q  <= '0;
            pend_q   <= '0;
            timer_q  <= '0;
            dir_q    <= 1'b1;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            moving_q <= 1'b0;
            door_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            pend_q   <= pend_d;
            timer_q  <= timer_d;
            dir_q    <= dir_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            moving_q <= moving_d;
            door_q   <= door_d;
        end
    end

    assign upsig     = up_q;
    assign dnsig     = dn_q;
    assign moving    = moving_q;
    assign door_open = door_q;
    assign floor     = floor_q;
    assign pend      = pend_q;

endmodule

// File: tb/tb_lift_sched.sv
// Directed bench for lift_sched: 8 floors, TRAVEL=4, DWELL=6, slowref one clk in four.
module tb_lift_sched;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       slowref = 1'b0;
    logic [7:0] call = '0;
    logic       upsig, dnsig, moving, door_open;
    logic [2:0] floor;
    logic [7:0] pend;

    int n_vec = 0;
    int n_bad = 0;
    int phase = 0;
    int n;

    lift_sched #(
        .NFLOOR(8),
        .FW    (3),
        .TRAVEL(4),
        .DWELL (6)
    ) dut (
        .clk      (clk),
        .resetb   (resetb),
        .slowref  (slowref),
        .call     (call),
        .upsig    (upsig),
        .dnsig    (dnsig),
        .moving   (moving),
        .door_open(door_open),
        .floor    (floor),
        .pend     (pend)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            phase   = (phase + 1) % 4;
            slowref = (phase == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 ns after the edge, slowref still holds its edge value.
    task automatic step();
        @(posedge clk);
        #1;
        check("updn_excl", {31'b0, upsig & dnsig}, 32'd0);
    endtask

    task automatic pulse(input logic [7:0] m);
        call = m;
        step();
        call = '0;
    endtask

    task automatic travel_ticks(output int t);
        logic [2:0] old;
        old = floor;
        t   = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (slowref) t++;
            if (floor != old) break;
        end
    endtask

    task automatic dwell_ticks(output int t);
        t = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (slowref) t++;
            if (!door_open) break;
        end
    endtask

    task automatic wait_floor(input int target, input string tag);
        for (int i = 0; i < 600; i++) begin
            if (floor == 3'(target)) break;
            step();
        end
        check(tag, {29'b0, floor}, target);
    endtask

    task automatic wait_arrive(input int target, input string tag);
        for (int i = 0; i < 600; i++) begin
            step();
            if (door_open) break;
        end
        check({tag, "_door"}, {31'b0, door_open}, 32'd1);
        check({tag, "_floor"}, {29'b0, floor}, target);
    endtask

    initial begin
        // 1. Reset
        repeat (3) step();
        check("rst_floor", {29'b0, floor}, 0);
        check("rst_pend", {24'b0, pend}, 0);
        check("rst_outs", {28'b0, upsig, dnsig, moving, door_open}, 0);
        @(negedge clk);
        resetb = 1'b1;
        repeat (20) step();
        check("idle_outs", {28'b0, upsig, dnsig, moving, door_open}, 0);
        check("idle_floor", {29'b0, floor}, 0);

        // 2. Single call up, 0 -> 5
        pulse(8'h20);
        check("s2_pend", {24'b0, pend}, 32'h20);
        check("s2_still_idle", {31'b0, moving}, 0);
        step();
        check("s2_up_moving", {30'b0, upsig, moving}, 32'h3);
        check("s2_floor0", {29'b0, floor}, 0);
        for (int f = 1; f <= 5; f++) begin
            travel_ticks(n);
            check("s2_travel_ticks", n, 4);
            check("s2_floor_step", {29'b0, floor}, f);
        end
        check("s2_door", {30'b0, door_open, moving}, 32'h2);
        check("s2_pend_clr", {24'b0, pend}, 0);
        check("s2_up_held", {31'b0, upsig}, 1);
        dwell_ticks(n);
        check("s2_dwell_ticks", n, 6);
        check("s2_idle", {28'b0, upsig, dnsig, moving, door_open}, 0);

        // 3. Call at current floor (first travel down to 2)
        pulse(8'h04);
        step();
        check("s3_reverse_dn", {30'b0, upsig, dnsig}, 32'h1);
        wait_arrive(2, "s3_arrive2");
        dwell_ticks(n);
        check("s3_dwell1", n, 6);
        pulse(8'h04);
        check("s3_pend_set", {24'b0, pend}, 32'h04);
        check("s3_no_door_yet", {31'b0, door_open}, 0);
        step();
        check("s3_door", {31'b0, door_open}, 1);
        check("s3_pend_clr", {24'b0, pend}, 0);
        check("s3_no_motion", {29'b0, upsig, dnsig, moving}, 0);
        n = 0;
        for (int i = 0; i < 64 && n < 4; i++) begin
            step();
            if (slowref) n++;
        end
        pulse(8'h04);
        check("s3_absorb_pend", {24'b0, pend}, 0);
        check("s3_absorb_door", {31'b0, door_open}, 1);
        dwell_ticks(n);
        check("s3_redwell_ticks", n, 6);
        check("s3_idle_floor", {29'b0, floor}, 2);

        // 4. Collect on the way up, then reverse
        pulse(8'h40);
        step();
        check("s4_up", {30'b0, upsig, dnsig}, 32'h2);
        wait_floor(3, "s4_at3");
        pulse(8'h12);
        check("s4_pend3", {24'b0, pend}, 32'h52);
        wait_arrive(4, "s4_stop4");
        check("s4_pend4", {24'b0, pend}, 32'h42);
        check("s4_up_held", {31'b0, upsig}, 1);
        dwell_ticks(n);
        check("s4_leave4_up", {30'b0, upsig, moving}, 32'h3);
        wait_arrive(6, "s4_stop6");
        check("s4_pend6", {24'b0, pend}, 32'h02);
        dwell_ticks(n);
        check("s4_leave6_dn", {29'b0, upsig, dnsig, moving}, 32'h3);
        wait_arrive(1, "s4_stop1");
        check("s4_pend1", {24'b0, pend}, 0);
        dwell_ticks(n);
        check("s4_final_idle", {28'b0, upsig, dnsig, moving, door_open}, 0);
        check("s4_final_floor", {29'b0, floor}, 1);

        // 5. Direction tie: get to floor 4 with dir down, then call 7 and 2 together
        pulse(8'h20);
        wait_arrive(5, "s5_pre5");
        dwell_ticks(n);
        pulse(8'h10);
        step();
        check("s5_pre_dn", {30'b0, upsig, dnsig}, 32'h1);
        wait_arrive(4, "s5_pre4");
        dwell_ticks(n);
        pulse(8'h84);
        check("s5_pend", {24'b0, pend}, 32'h84);
        step();
        check("s5_dn_first", {30'b0, upsig, dnsig}, 32'h1);
        wait_arrive(2, "s5_stop2");
        dwell_ticks(n);
        check("s5_then_up", {30'b0, upsig, dnsig}, 32'h2);
        wait_arrive(7, "s5_stop7");
        dwell_ticks(n);
        check("s5_done", {24'b0, pend}, 0);
        check("s5_idle", {31'b0, moving}, 0);

        // 6. Reset mid-move between 3 and 4
        pulse(8'h08);
        wait_arrive(3, "s6_pre3");
        dwell_ticks(n);
        pulse(8'h90);
        check("s6_pend", {24'b0, pend}, 32'h90);
        step();
        check("s6_moving_up", {30'b0, upsig, moving}, 32'h3);
        repeat (5) step();
        check("s6_mid_floor", {29'b0, floor}, 3);
        #2;
        resetb = 1'b0;
        #1;
        check("s6_async_floor", {29'b0, floor}, 0);
        check("s6_async_pend", {24'b0, pend}, 0);
        check("s6_async_outs", {28'b0, upsig, dnsig, moving, door_open}, 0);
        repeat (2) step();
        @(negedge clk);
        resetb = 1'b1;
        repeat (40) step();
        check("s6_post_outs", {28'b0, upsig, dnsig, moving, door_open}, 0);
        check("s6_post_state", {21'b0, floor, pend}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lift_sched.md
# lift_sched

Lift motion scheduler for the car controller. It latches floor call buttons and chooses the travel direction with a SCAN (elevator) policy: it keeps going one way while calls remain ahead, then reverses. It times floor-to-floor travel and door dwell on the shared `slowref` tick. It drives `upsig`/`dnsig`/`moving` to the up/down display block and `floor` to the floor-indicator logic.

## Interface
- `NFLOOR`, default 8: number of floors, at least 2.
- `FW`, default 3: floor index width, equal to ceil(log2(NFLOOR)).
- `TRAVEL`, default 4: `slowref` ticks per one-floor move, at least 1.
- `DWELL`, default 6: `slowref` ticks the door stays open, at least 1.
- `clk`, in, 1: system clock.
- `resetb`, in, 1: asynchronous, active-low reset.
- `slowref`, in, 1: one-`clk`-wide timebase tick enable.
- `call`, in, NFLOOR: floor call buttons, one per floor. Level or pulse; any high cycle registers a request.
- `upsig`, out, 1: car committed to upward travel.
- `dnsig`, out, 1: car committed to downward travel.
- `moving`, out, 1: car travelling between floors.
- `door_open`, out, 1: door open at `floor`.
- `floor`, out, FW: current floor index, 0 to NFLOOR-1.
- `pend`, out, NFLOOR: latched outstanding requests.

## Operation
- **Reset values:** state IDLE, `floor`=0, `pend`=0, `upsig`=`dnsig`=`moving`=`door_open`=0. The internal direction preference `dir` resets to up.
- **Request latch:** `pend[i]` is set the clk after `call[i]` is high. It is cleared only on the door-open transition at floor i.
- **Absorbed calls:** while in DOOR, `call[floor]` is absorbed and not latched, and the dwell timer is reloaded to DWELL.
- **State IDLE** (`upsig`=`dnsig`=0), evaluated every clk, in priority order:
  - `pend[floor]` set: go to DOOR.
  - Calls exist ahead in `dir`: go to MOVE in `dir`.
  - Calls exist only behind: flip `dir` and go to MOVE.
  - Otherwise: stay in IDLE.
- **State MOVE** (`moving`=1):
  - `upsig`=`dir`, `dnsig`=!`dir`.
  - The travel timer loads TRAVEL-1 on entry and decrements on each `slowref`.
  - On a `slowref` with the timer at 0, `floor` steps ±1 in `dir`, then:
    - `pend[new floor]` set: go to DOOR.
    - Otherwise, calls remain ahead: reload the timer and stay in MOVE.
    - Otherwise, calls remain behind: flip `dir`, reload the timer and stay in MOVE.
    - Otherwise: go to IDLE.
- **State DOOR** (`door_open`=1, `moving`=0):
  - On entry, clear `pend[floor]` and load the dwell timer with DWELL-1.
  - `upsig`/`dnsig` hold their values from the previous state; both are 0 if entered from IDLE.
  - On a `slowref` with the timer at 0, apply the IDLE decision rules, skipping the `pend[floor]` rule. If no calls remain, go to IDLE.
- **Range:** `floor` never leaves 0..NFLOOR-1, because MOVE only starts toward an existing request.
- **Direction outputs:** `upsig` and `dnsig` are never both 1.
- **Simultaneous events:**
  - A call at the arrival floor on the arrival cycle is treated as served.
  - Calls at other floors on any cycle are latched normally.
- **Reset mid-operation:** immediately restores all reset values. No motion or request survives the reset.

## Timing
- `call` to `pend`: 1 clk.
- IDLE to MOVE or DOOR: 1 clk after `pend` updates. No `slowref` is required for a departure decision.
- All outputs are registered and change on the same clk edge as the state change.
- **One-floor travel:** exactly TRAVEL `slowref` ticks. `floor` updates on the tick edge that ends the travel.
- **Dwell:** DWELL ticks, counted from the first tick after DOOR entry. Each absorbed call restarts the full DWELL.
- The timers count only when `slowref`=1 and hold otherwise.

## Test plan
All scenarios use NFLOOR=8, TRAVEL=4, DWELL=6, with `slowref` high one clk in every 4.
1. **Reset:** assert `resetb`=0 mid-simulation -> all outputs and `pend` are 0 and `floor`=0 asynchronously. After release, stays IDLE with no calls.
2. **Single call up:** at floor 0, pulse `call[5]` -> `pend`=8'h20 next clk, then `upsig`=`moving`=1. `floor` increments every 4 ticks. At floor 5: `door_open`=1, `moving`=0, `pend`=0. After 6 ticks: IDLE, `upsig`=0.
3. **Call at current floor:** IDLE at floor 2, pulse `call[2]` -> `pend[2]` high for 1 clk, then `door_open`=1 with no motion. Repulse `call[2]` at tick 4 of dwell -> `pend` stays 0 and the door stays open 6 more ticks.
4. **Collect and reverse:** moving up from floor 3 to target 6, pulse `call[1]` and `call[4]` -> stops at 4 (door), then 6 (door). Then `dnsig`=1, travels to 1 and stops there. Final state IDLE at floor 1.
5. **Direction tie:** last `dir` down, IDLE at floor 4, with `call[7]` and `call[2]` pulsed on the same clk -> goes down to 2 first, then up to 7.
6. **Reset mid-move:** assert `resetb` while moving between floors 3 and 4 with `pend`=8'h90 -> `floor`=0, `pend`=0, IDLE, and no residual `moving`.
